// File: rtl/kypd_pkg.sv
// kypd_pkg: shared constants and helpers for the 4x4 keypad scanner.
//   NUM_COLS / NUM_ROWS / NUM_KEYS : matrix geometry
//   KEYMAP                         : hex legend per key, index = col*4 + row
//   pop_class()                    : classify a snapshot as zero / one / many keys
//   onehot_to_index()              : bit position of a one-hot snapshot
package kypd_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef enum logic [1:0] {
        PC_ZERO = 2'd0,
        PC_ONE  = 2'd1,
        PC_MANY = 2'd2
    } pop_class_e;

    // Printed legend of the Pmod KYPD, column-major.
    localparam logic [3:0] KEYMAP [NUM_KEYS] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    // v & (v-1) clears the lowest set bit; zero afterwards means a single bit.
    function automatic pop_class_e pop_class(input logic [NUM_KEYS-1:0] v);
        if (v == '0) begin
            return PC_ZERO;
        end
        if ((v & (v - 16'd1)) == '0) begin
            return PC_ONE;
        end
        return PC_MANY;
    endfunction

    function automatic logic [3:0] onehot_to_index(input logic [NUM_KEYS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/kypd_scanner_if.sv
// kypd_scanner_if: keypad pins plus the decoded key outputs.
//   col_n     : column drive, active-low, one bit low at a time
//   row_n     : raw row inputs, active-low, asynchronous
//   key_code  : hex value of the last single-key press
//   key_valid : one-cycle strobe, key_code is new on that same cycle
//   key_down  : committed snapshot has any key pressed
//   multi_key : committed snapshot has more than one key pressed
//   snapshot  : committed key state, bit = col*4 + row, 1 = pressed
// key_valid is a pure strobe with no ready: the consumer must capture
// key_code on the cycle key_valid is high; there is no back-pressure.
interface kypd_scanner_if;
    import kypd_pkg::*;

    logic [NUM_COLS-1:0] col_n;
    logic [NUM_ROWS-1:0] row_n;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                key_down;
    logic                multi_key;
    logic [NUM_KEYS-1:0] snapshot;

    modport master (
        output col_n, key_code, key_valid, key_down, multi_key, snapshot,
        input  row_n
    );

    modport slave (
        input  col_n, key_code, key_valid, key_down, multi_key, snapshot,
        output row_n
    );

endinterface

// File: rtl/kypd_frame_debounce.sv
// kypd_frame_debounce: whole-keypad debouncer working on complete frames.
//   clk, reset  : clock and synchronous active-high reset
//   frame_i     : assembled 16-bit keypad frame (valid when frame_end_i)
//   frame_end_i : one cycle per frame, on the last column's sample cycle
//   commit_o    : high on the frame-end cycle that commits a new snapshot
//   snapshot_o  : committed snapshot; still holds the old value while
//                 commit_o is high and takes the new one on the next cycle
module kypd_frame_debounce
    import kypd_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] frame_i,
    input  logic                frame_end_i,
    output logic                commit_o,
    output logic [NUM_KEYS-1:0] snapshot_o
);

    localparam logic [3:0] TARGET = 4'(DEBOUNCE_FRAMES);

    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                same;
    logic                commit;

    assign same = (frame_i == prev_q);

    // Commit only on the step into TARGET, so a saturated count never re-commits.
    assign commit = frame_end_i && same && (cnt_q == TARGET - 4'd1) &&
                    (frame_i != snap_q);

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        snap_d = snap_q;
        if (frame_end_i) begin
            prev_d = frame_i;
            if (!same) begin
                cnt_d = '0;
            end else if (cnt_q < TARGET) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
        if (commit) begin
            snap_d = frame_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign commit_o   = commit;
    assign snapshot_o = snap_q;

endmodule

// File: rtl/kypd_scanner.sv
// kypd_scanner: 4x4 matrix keypad scanner with frame debounce.
//   clk, reset : clock and synchronous active-high reset
//   bus        : kypd_scanner_if.master (col_n/row_n pins, key_code,
//                key_valid, key_down, multi_key, snapshot)
// Each column is driven low for SCAN_DIV cycles; its rows are sampled on the
// last cycle of that window. Four columns make a frame, which is handed to
// the debouncer. A committed change from no keys to exactly one key emits a
// key_valid strobe with the mapped hex code.
module kypd_scanner
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV        = 25000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic           clk,
    input  logic           reset,
    kypd_scanner_if.master bus
);

    localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic [NUM_ROWS-1:0] rows;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [NUM_KEYS-1:0] frame_q, frame_d, frame_now;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_down_q, key_down_d;
    logic                multi_q, multi_d;
    logic                sample, frame_end;
    logic                commit;
    logic [NUM_KEYS-1:0] snapshot;

    assign rows      = ~row_sync_q;
    assign sample    = (dwell_q == DWELL_LAST);
    assign frame_end = sample && (col_q == 2'd3);

    // Frame as it looks with the current column's rows merged in, so the
    // frame-end comparison already sees column 3.
    always_comb begin
        frame_now = frame_q;
        frame_now[{col_q, 2'b00} +: NUM_ROWS] = rows;
    end

    always_comb begin
        dwell_d = dwell_q + DW'(1);
        col_d   = col_q;
        col_n_d = col_n_q;
        frame_d = frame_q;
        if (sample) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
            col_n_d = {col_n_q[NUM_COLS-2:0], col_n_q[NUM_COLS-1]};
            frame_d = frame_now;
        end
    end

    kypd_frame_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk         (clk),
        .reset       (reset),
        .frame_i     (frame_now),
        .frame_end_i (frame_end),
        .commit_o    (commit),
        .snapshot_o  (snapshot)
    );

    // Only a fresh single press (old snapshot empty) is an event; releases,
    // added keys and chords update the snapshot silently.
    always_comb begin
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (commit && (pop_class(frame_now) == PC_ONE) &&
            (pop_class(snapshot) == PC_ZERO)) begin
            key_valid_d = 1'b1;
            key_code_d  = KEYMAP[onehot_to_index(frame_now)];
        end
        key_down_d = |snapshot;
        multi_d    = (pop_class(snapshot) == PC_MANY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            dwell_q     <= '0;
            col_q       <= '0;
            col_n_q     <= 4'b1110;
            frame_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            row_meta_q  <= bus.row_n;
            row_sync_q  <= row_meta_q;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            frame_q     <= frame_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            multi_q     <= multi_d;
        end
    end

    assign bus.col_n     = col_n_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_down  = key_down_q;
    assign bus.multi_key = multi_q;
    assign bus.snapshot  = snapshot;

endmodule

// File: tb/tb_kypd_scanner.sv
// tb_kypd_scanner: bench for kypd_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2.
// A keypad matrix model turns the pressed-key vector into row_n from col_n.
// Position p counts rising edges since the last reset edge; with a 16-cycle
// frame, frame end k lands on edge p = 16*k.
module tb_kypd_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  row_model;
    int          p;
    int          checks;
    int          errors;
    logic [3:0]  exp_q[$];

    kypd_scanner_if kif ();

    kypd_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (kif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad matrix model ----------------
    always_comb begin
        row_model = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[c*4+r] && !kif.col_n[c]) begin
                    row_model[r] = 1'b0;
                end
            end
        end
    end
    assign kif.row_n = row_model;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && kif.key_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected t=%0t code=%h expected no strobe", $time, kif.key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (kif.key_code !== e) begin
                    errors++;
                    $display("FAIL strobe_code t=%0t got %h expected %h", $time, kif.key_code, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        p = 0;
    endtask

    task automatic step_to(input int t);
        while (p < t) begin
            @(negedge clk);
            p++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [3:0] e;
        keys = 16'h0;
        do_reset(2);
        checks++; if (kif.col_n !== 4'b1110) begin errors++; $display("FAIL rst_col_n got %b expected 1110", kif.col_n); end
        checks++; if (kif.key_code !== 4'h0) begin errors++; $display("FAIL rst_key_code got %h expected 0", kif.key_code); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid got %b expected 0", kif.key_valid); end
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL rst_key_down got %b expected 0", kif.key_down); end
        checks++; if (kif.multi_key !== 1'b0) begin errors++; $display("FAIL rst_multi_key got %b expected 0", kif.multi_key); end
        checks++; if (kif.snapshot !== 16'h0) begin errors++; $display("FAIL rst_snapshot got %h expected 0", kif.snapshot); end
        for (int t = 0; t < 320; t++) begin
            step_to(t);
            e = ~(4'b0001 << ((t / 4) % 4));
            checks++;
            if (kif.col_n !== e) begin
                errors++;
                $display("FAIL col_n_seq p=%0d got %b expected %b", t, kif.col_n, e);
            end
        end
        checks++; if (kif.key_down !== 1'b0 || kif.snapshot !== 16'h0) begin errors++; $display("FAIL idle_outputs key_down=%b snapshot=%h expected 0/0", kif.key_down, kif.snapshot); end
    endtask

    task automatic test_press;
        do_reset(2);
        keys = 16'h0040;
        exp_q.push_back(4'h8);
        step_to(47);
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL press_early got %b expected 0", kif.key_valid); end
        step_to(48);
        checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL press_valid got %b expected 1", kif.key_valid); end
        checks++; if (kif.key_code !== 4'h8) begin errors++; $display("FAIL press_code got %h expected 8", kif.key_code); end
        checks++; if (kif.snapshot !== 16'h0040) begin errors++; $display("FAIL press_snapshot got %h expected 0040", kif.snapshot); end
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL press_key_down_lag got %b expected 0", kif.key_down); end
        step_to(49);
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL press_one_cycle got %b expected 0", kif.key_valid); end
        checks++; if (kif.key_down !== 1'b1) begin errors++; $display("FAIL press_key_down got %b expected 1", kif.key_down); end
        checks++; if (kif.multi_key !== 1'b0) begin errors++; $display("FAIL press_multi got %b expected 0", kif.multi_key); end
        keys = 16'h0;
        step_to(100);
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL release_key_down got %b expected 0", kif.key_down); end
        checks++; if (kif.key_code !== 4'h8) begin errors++; $display("FAIL release_code_hold got %h expected 8", kif.key_code); end
    endtask

    task automatic test_bounce;
        do_reset(2);
        keys = 16'h0;
        for (int k = 0; k < 7; k++) begin
            step_to(5 * k);
            keys = (k % 2 == 0) ? 16'h0040 : 16'h0000;
        end
        exp_q.push_back(4'h8);
        step_to(63);
        checks++; if (kif.snapshot !== 16'h0) begin errors++; $display("FAIL bounce_early_snapshot got %h expected 0", kif.snapshot); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL bounce_early_valid got %b expected 0", kif.key_valid); end
        step_to(64);
        checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL bounce_valid got %b expected 1", kif.key_valid); end
        checks++; if (kif.snapshot !== 16'h0040) begin errors++; $display("FAIL bounce_snapshot got %h expected 0040", kif.snapshot); end
    endtask

    task automatic test_multi;
        do_reset(2);
        keys = 16'h0020;
        exp_q.push_back(4'h5);
        step_to(48);
        checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h5) begin errors++; $display("FAIL multi_first valid=%b code=%h expected 1/5", kif.key_valid, kif.key_code); end
        step_to(64);
        keys = 16'h1020;
        step_to(112);
        checks++; if (kif.snapshot !== 16'h1020) begin errors++; $display("FAIL multi_snapshot got %h expected 1020", kif.snapshot); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL multi_no_strobe got %b expected 0", kif.key_valid); end
        step_to(113);
        checks++; if (kif.multi_key !== 1'b1) begin errors++; $display("FAIL multi_flag got %b expected 1", kif.multi_key); end
        checks++; if (kif.key_down !== 1'b1) begin errors++; $display("FAIL multi_key_down got %b expected 1", kif.key_down); end
        step_to(128);
        keys = 16'h0;
        step_to(176);
        checks++; if (kif.snapshot !== 16'h0) begin errors++; $display("FAIL rel_snapshot got %h expected 0", kif.snapshot); end
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rel_no_strobe got %b expected 0", kif.key_valid); end
        step_to(177);
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL rel_key_down got %b expected 0", kif.key_down); end
        checks++; if (kif.multi_key !== 1'b0) begin errors++; $display("FAIL rel_multi got %b expected 0", kif.multi_key); end
        checks++; if (kif.key_code !== 4'h5) begin errors++; $display("FAIL rel_code_hold got %h expected 5", kif.key_code); end
    endtask

    task automatic test_glitch;
        do_reset(2);
        keys = 16'h0;
        step_to(16);
        keys = 16'h0800;
        step_to(32);
        keys = 16'h0;
        step_to(112);
        checks++; if (kif.snapshot !== 16'h0) begin errors++; $display("FAIL glitch_snapshot got %h expected 0", kif.snapshot); end
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL glitch_key_down got %b expected 0", kif.key_down); end
    endtask

    task automatic test_reset_mid;
        do_reset(2);
        keys = 16'h0008;
        exp_q.push_back(4'h0);
        step_to(48);
        checks++; if (kif.key_valid !== 1'b1 || kif.snapshot !== 16'h0008) begin errors++; $display("FAIL mid_first valid=%b snapshot=%h expected 1/0008", kif.key_valid, kif.snapshot); end
        step_to(55);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (kif.col_n !== 4'b1110) begin errors++; $display("FAIL mid_rst_col_n got %b expected 1110", kif.col_n); end
        checks++; if (kif.key_down !== 1'b0) begin errors++; $display("FAIL mid_rst_key_down got %b expected 0", kif.key_down); end
        checks++; if (kif.snapshot !== 16'h0) begin errors++; $display("FAIL mid_rst_snapshot got %h expected 0", kif.snapshot); end
        checks++; if (kif.key_valid !== 1'b0 || kif.multi_key !== 1'b0 || kif.key_code !== 4'h0) begin errors++; $display("FAIL mid_rst_outs valid=%b multi=%b code=%h expected 0/0/0", kif.key_valid, kif.multi_key, kif.key_code); end
        reset = 1'b0;
        p = 0;
        exp_q.push_back(4'h0);
        step_to(4);
        checks++; if (kif.col_n !== 4'b1101) begin errors++; $display("FAIL mid_restart_col got %b expected 1101", kif.col_n); end
        step_to(47);
        checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL mid_early got %b expected 0", kif.key_valid); end
        step_to(48);
        checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b expected 1", kif.key_valid); end
        checks++; if (kif.snapshot !== 16'h0008) begin errors++; $display("FAIL mid_snapshot got %h expected 0008", kif.snapshot); end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        reset  = 1'b1;
        keys   = 16'h0;
        p      = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_press();
        test_bounce();
        test_multi();
        test_glitch();
        test_reset_mid();
        step_to(p + 4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kypd_scanner.md
Name: kypd_scanner

Overview:
- Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4 Pmod KYPD matrix keypad one column at a time and samples the rows.
- Debounces whole-keypad snapshots and reports single key presses as a hex code plus a one-cycle strobe.
- Sits beside LED_MUX in the Nexys4DDR top level. Feeds the switches/GPIO read path so MIPS software can poll keypad input.

Parameters:
- SCAN_DIV, 25000, clk cycles each column is driven before its rows are sampled. Range 2..2^20.
- DEBOUNCE_FRAMES, 4, consecutive identical full-keypad frames required before a change is committed. Range 1..15.

Ports:
- clk  in  1  system clock, 100 MHz on board.
- reset  in  1  synchronous, active-high reset.
- col_n  out  4  column drive, active-low, exactly one bit low at any time.
- row_n  in  4  raw row inputs, active-low, asynchronous (pulled up on board).
- key_code  out  4  hex value of the last committed single key.
- key_valid  out  1  one-cycle strobe; key_code is updated on the same cycle.
- key_down  out  1  high while the committed snapshot has any key pressed.
- multi_key  out  1  high while the committed snapshot has more than one key pressed.
- snapshot  out  16  committed key state, bit index = col*4 + row, 1 = pressed.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, on ports clk and reset. All state changes on posedge clk.
- Reset values: col_n=4'b1110, key_code=0, key_valid=0, key_down=0, multi_key=0, snapshot=0. Internal counters, frame buffer, previous frame and stability count are all cleared.
- Input sync: row_n passes through a 2-flop synchronizer and is inverted to rows[3:0] (active-high).
- Scan counter:
  - dwell counts 0..SCAN_DIV-1.
  - At dwell==SCAN_DIV-1: rows are written into frame[col*4 +: 4], dwell wraps to 0, col advances (3 wraps to 0), and col_n rotates on the next cycle.
  - The sample point is the last dwell cycle, so the 2-cycle sync latency and line settling fall inside the dwell window.
- Frame end = the sample cycle of col 3. The stability counter then updates against the assembled frame, including the col-3 rows sampled that cycle:
  - frame != prev_frame: stable_cnt <= 0.
  - frame == prev_frame and stable_cnt < DEBOUNCE_FRAMES: stable_cnt increments.
  - prev_frame <= frame in either case.
- Commit: on the frame end where stable_cnt reaches DEBOUNCE_FRAMES (the transition only) and frame != snapshot, snapshot <= frame. After that, stable_cnt saturates and no re-commit occurs.
- Event rule, applied on the commit cycle:
  - If the new snapshot has exactly one bit set and the old snapshot was zero: key_valid=1 for that one cycle, and key_code = KEYMAP[bit index].
  - Releases, additional keys pressed while held, and chords produce no strobe.
  - key_code holds its value until the next valid press.
- key_down and multi_key are registered from the snapshot and change on the cycle after the commit.
- Latency: a clean press, stable from the start of a frame, commits DEBOUNCE_FRAMES+1 frame ends later. One frame = 4*SCAN_DIV cycles.
- Bounce: any differing frame restarts the count. A press shorter than (DEBOUNCE_FRAMES+1) frames is never reported.
- Reset mid-scan: the scan restarts at col 0. A key held through reset is reported as a new press after debounce, because snapshot was cleared.
- KEYMAP, index col*4+row:
  - col0 rows 0..3 = 1,4,7,0
  - col1 = 2,5,8,F
  - col2 = 3,6,9,E
  - col3 = A,B,C,D

Decomposition:
- Shared package kypd_pkg holds:
  - KEYMAP 16x4 constant
  - NUM_COLS=4, NUM_ROWS=4
  - a popcount-class helper for the "zero / one / many" classification
  - the one-hot-to-index encode function
- One sub-module, kypd_frame_debounce. It takes frame, frame_end and the DEBOUNCE_FRAMES parameter, and outputs commit and snapshot.
- The scan counter, synchronizer, keymap and event logic stay in kypd_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, frame = 16 cycles):
- Reset, no keys -> col_n sequence 1110,1101,1011,0111 repeating, each held 4 cycles. No key_valid for 20 frames; all outputs 0.
- Hold the key at col1/row2 clean from frame start -> exactly one key_valid pulse with key_code=4'h8 at the 3rd frame end (+1 cycle for key_down=1); snapshot=16'h0040.
- Same key bouncing (toggle every 5 cycles for 2 frames, then stable) -> no strobe during the bounce. A single strobe with key_code=8 arrives 3 frame ends after the bounce stops.
- Hold key 5 (col1/row1), then also press col3/row0 -> one strobe code=5. On the second commit multi_key=1 and no strobe; on full release key_down=0, multi_key=0 and key_code stays 5.
- 1-frame glitch on col2/row3 -> snapshot stays 0 and no strobe.
- Key 0 (col0/row3) held, assert reset for 3 cycles mid-frame -> outputs return to their reset values. The scan restarts at col_n=1110, and after 3 frame ends there is a fresh strobe with key_code=0.
